// File: rtl/seven_seg_scanner_if.sv
// Host-side bundle for the seven-segment scanner: buffer writes, scroll advance, display drive.
interface seven_seg_scanner_if;
    logic       adv;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    modport master (
        output adv, wr_en, wr_addr, wr_data,
        input  an, seg, frame_done
    );

    modport slave (
        input  adv, wr_en, wr_addr, wr_data,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner showing a scrolling window over a 16-entry hex buffer.
module seven_seg_scanner #(
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned ON_CYC    = 6
) (
    input  logic               clk,
    input  logic               reset,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [0:0]  ST_BLANK = 1'b0;
    localparam logic [0:0]  ST_ON    = 1'b1;

    logic [0:0]       state, state_n;
    logic [1:0]       digit, digit_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       ptr, ptr_n;
    logic             pending, pending_n;
    logic             boundary;
    logic [3:0]       rd_addr;
    logic [3:0]       an_n;
    logic [6:0]       seg_n;
    logic [3:0]       msg_buf [16];

    function automatic logic [6:0] hex_decode(input logic [3:0] c);
        case (c)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    // Leftmost digit (3) shows buf[ptr], rightmost (0) shows buf[ptr+3].
    assign rd_addr = ptr + 4'd3 - {2'b00, digit};

    // Message buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) msg_buf[i] <= '0;
        end else if (bus.wr_en) begin
            msg_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_BLANK;
            digit          <= 2'd3;
            cnt            <= '0;
            ptr            <= '0;
            pending        <= 1'b0;
            bus.an         <= 4'b1111;
            bus.seg        <= 7'b1111111;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            digit          <= digit_n;
            cnt            <= cnt_n;
            ptr            <= ptr_n;
            pending        <= pending_n;
            bus.an         <= an_n;
            bus.seg        <= seg_n;
            bus.frame_done <= boundary;
        end
    end

    // Next-state and output decode; an tracks the next state so it lines up with the slot.
    always_comb begin
        state_n  = state;
        digit_n  = digit;
        cnt_n    = cnt + CNT_W'(1);
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state_n = ST_ON;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (cnt == CNT_W'(ON_CYC - 1)) begin
                    state_n  = ST_BLANK;
                    cnt_n    = '0;
                    digit_n  = digit - 2'd1;
                    boundary = (digit == 2'd0);
                end
            end
        endcase

        an_n  = (state_n == ST_ON) ? ~(4'b0001 << digit_n) : 4'b1111;
        seg_n = (state == ST_BLANK && cnt == '0) ? hex_decode(msg_buf[rd_addr]) : bus.seg;

        // An advance landing on the boundary cycle is folded in before the pointer step.
        pending_n = pending | bus.adv;
        ptr_n     = ptr;
        if (boundary && pending_n) begin
            ptr_n     = ptr + 4'd1;
            pending_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner at default timing (32-cycle frames).
module tb_seven_seg_scanner;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   k = 0;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(.BLANK_CYC(2), .ON_CYC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] c);
        case (c)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Anode pattern for frame cycle kk: 2 blank cycles then 6 lit cycles per slot, digit 3 first.
    function automatic logic [3:0] exp_an(input int kk);
        int slot;
        slot = (kk % 32) / 8;
        if ((kk % 8) < 2) exp_an = 4'b1111;
        else exp_an = ~(4'b1000 >> slot);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k = (k + 1) % 32;
    endtask

    task automatic run_to_k(input int target);
        do tick(); while (k != target);
    endtask

    task automatic pulse_adv();
        bus.adv = 1'b1;
        tick();
        bus.adv = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [3:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Called at k==0; checks each lit slot's anodes/segments and the next frame_done pulse.
    task automatic check_frame(input string tag, input logic [3:0] c3, input logic [3:0] c2,
                               input logic [3:0] c1, input logic [3:0] c0);
        logic [3:0] ch [4];
        ch[0] = c3; ch[1] = c2; ch[2] = c1; ch[3] = c0;
        for (int s = 0; s < 4; s++) begin
            run_to_k(s * 8 + 4);
            check({tag, "_an"},  8'(bus.an),  8'(exp_an(k)));
            check({tag, "_seg"}, 8'(bus.seg), 8'(hex7(ch[s])));
            check({tag, "_fd0"}, 8'(bus.frame_done), 8'd0);
        end
        run_to_k(0);
        check({tag, "_fd"}, 8'(bus.frame_done), 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.adv = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an",  8'(bus.an),  8'h0F);
        check("rst_seg", 8'(bus.seg), 8'h7F);
        check("rst_fd",  8'(bus.frame_done), 8'd0);

        // Reset release: cycle 0 is BLANK of digit 3, outputs still at reset values.
        reset = 1'b0;
        k = 0;
        check("c0_an",  8'(bus.an),  8'h0F);
        check("c0_seg", 8'(bus.seg), 8'h7F);
        for (int c = 1; c <= 32; c++) begin
            tick();
            check($sformatf("f1_an_c%0d", c),  8'(bus.an),  8'(exp_an(c)));
            check($sformatf("f1_seg_c%0d", c), 8'(bus.seg), 8'(7'b1000000));
            check($sformatf("f1_fd_c%0d", c),  8'(bus.frame_done), (c == 32) ? 8'd1 : 8'd0);
        end

        // Fill buffer 0..F, then advance mid-frame: current frame keeps ptr=0.
        for (int i = 0; i < 16; i++) write(4'(i), 4'(i));
        pulse_adv();
        run_to_k(20);
        check("pre_adv_d1", 8'(bus.seg), 8'(hex7(4'd2)));
        run_to_k(28);
        check("pre_adv_d0", 8'(bus.seg), 8'(hex7(4'd3)));
        run_to_k(0);
        check("adv_fd", 8'(bus.frame_done), 8'd1);
        check_frame("adv1", 4'd1, 4'd2, 4'd3, 4'd4);

        // 14 more advances -> ptr=15, window wraps the buffer end.
        for (int i = 0; i < 14; i++) begin
            run_to_k(10);
            pulse_adv();
            run_to_k(0);
        end
        check_frame("ptr15", 4'hF, 4'h0, 4'h1, 4'h2);
        run_to_k(10);
        pulse_adv();
        run_to_k(0);
        check_frame("wrap0", 4'h0, 4'h1, 4'h2, 4'h3);

        // Three advances in one frame coalesce into a single step.
        run_to_k(5);  pulse_adv();
        run_to_k(12); pulse_adv();
        run_to_k(20); pulse_adv();
        run_to_k(0);
        check_frame("coalesce", 4'h1, 4'h2, 4'h3, 4'h4);

        // Advance on the boundary cycle itself is applied at that boundary.
        run_to_k(31);
        pulse_adv();
        check("bnd_fd", 8'(bus.frame_done), 8'd1);
        check_frame("bnd_adv", 4'h2, 4'h3, 4'h4, 4'h5);

        // Simultaneous write and advance both take effect.
        run_to_k(10);
        bus.adv = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 4'hA;
        tick();
        bus.adv = 1'b0; bus.wr_en = 1'b0;
        run_to_k(0);
        check_frame("wr_adv", 4'h3, 4'h4, 4'hA, 4'h6);

        // Write the lit digit 0 entry (buf[6]); segments hold until its next blank load.
        run_to_k(27);
        write(4'd6, 4'd8);
        check("hold_a", 8'(bus.seg), 8'(hex7(4'd6)));
        run_to_k(31);
        check("hold_b", 8'(bus.seg), 8'(hex7(4'd6)));
        run_to_k(28);
        check("new_val", 8'(bus.seg), 8'(hex7(4'd8)));

        // Reset during digit 1's ON phase blanks immediately; scan restarts at digit 3.
        run_to_k(20);
        check("pre_rst_an", 8'(bus.an), 8'b1101);
        reset = 1'b1;
        tick();
        check("mid_rst_an",  8'(bus.an),  8'h0F);
        check("mid_rst_seg", 8'(bus.seg), 8'h7F);
        check("mid_rst_fd",  8'(bus.frame_done), 8'd0);
        reset = 1'b0;
        k = 0;
        tick();
        check("rst_c1_an",  8'(bus.an),  8'h0F);
        check("rst_c1_seg", 8'(bus.seg), 8'(7'b1000000));
        tick();
        check("rst_c2_an",  8'(bus.an),  8'b0111);
        run_to_k(0);
        check("rst_fd", 8'(bus.frame_done), 8'd1);
        check_frame("post_rst", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have the parameter BLANK_CYC, default 2, which is the number of blanking cycles per digit slot (legal range 1..255).
REQ-002 The block SHALL have the parameter ON_CYC, default 6, which is the number of lit cycles per digit slot (legal range 1..255).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port adv, input, 1 bit: single-cycle pulse from the button debouncer that advances the message window by one character.
REQ-006 The block SHALL have the port wr_en, input, 1 bit: message buffer write strobe.
REQ-007 The block SHALL have the port wr_addr, input, 4 bits: message buffer write address.
REQ-008 The block SHALL have the port wr_data, input, 4 bits: hex character to write.
REQ-009 The block SHALL have the port an, output, 4 bits: active-low digit anodes; an[3] is the leftmost digit.
REQ-010 The block SHALL have the port seg, output, 7 bits: active-low cathodes {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have the port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 The block SHALL contain a 16x4 message buffer and a 4-bit window pointer ptr.
REQ-014 Digit d (3..0) SHALL display buf[(ptr + 3 - d) mod 16]; the pointer wraps from 15 to 0.
REQ-015 The FSM SHALL have two states, BLANK and ON, and a 2-bit digit index that scans 3, 2, 1, 0, then back to 3.
REQ-016 BLANK SHALL last exactly BLANK_CYC cycles with an = 4'b1111, then transition to ON.
REQ-017 ON SHALL last exactly ON_CYC cycles with an = active-low one-hot of the digit index (digit 3 -> 4'b0111, digit 0 -> 4'b1110), then transition to BLANK of the next digit.
REQ-018 One frame SHALL be 4*(BLANK_CYC+ON_CYC) cycles (32 at defaults).
REQ-019 seg SHALL load the decoded character on the first BLANK cycle of each slot and hold it unchanged through that slot's ON phase.
REQ-020 The hex decode SHALL be 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-021 A write SHALL update buf[wr_addr] on the clock edge after wr_en is sampled high; the new value appears no earlier than the next BLANK load of the affected digit, so the segment pattern never changes while that digit is lit.
REQ-022 A pulse on adv SHALL set a pending flag; further adv pulses while the flag is already set SHALL be coalesced into it (ignored).
REQ-023 At the frame boundary (the last ON cycle of digit 0 completing), if the pending flag is set, ptr SHALL become ptr+1 mod 16 and the flag SHALL clear.
REQ-024 The first seg load of the new frame SHALL use the updated ptr.
REQ-025 An adv arriving in the same cycle as a frame boundary SHALL be applied at that boundary.
REQ-026 frame_done SHALL be high for exactly the first BLANK cycle of digit 3 of each new frame, and SHALL NOT pulse after reset until one full frame has completed.
REQ-027 A write and an adv in the same cycle SHALL both take effect independently.

Reset
REQ-028 While reset is high, on every edge: state = BLANK, digit = 3, phase counter = 0, ptr = 0, pending flag = 0, all 16 buffer entries = 0, an = 4'b1111, seg = 7'b1111111, frame_done = 0.
REQ-029 Reset asserted mid-slot SHALL blank the display on the next edge; no partial slot SHALL resume.
REQ-030 The first cycle with reset low SHALL be BLANK cycle 0 of digit 3, and seg SHALL load decode(buf[0]) = 7'b1000000 on that edge.

Verification
REQ-031 Reset release at defaults, empty buffer -> an = 1111 for cycles 0-1, 0111 for cycles 2-7, 1111 for cycles 8-9, 1011 for cycles 10-15, ..., 1110 for cycles 26-31; frame_done = 1 at cycle 32 only; seg = 1000000 throughout.
REQ-032 Write buf[0..15] = 0..F, then pulse adv once mid-frame -> no change until the boundary; the next frame shows digits 3..0 = 1,2,3,4 (seg 1111001, 0100100, 0110000, 0011001).
REQ-033 Pulse adv 16 times, one per frame -> ptr wraps; the window returns to 0,1,2,3.
REQ-034 Pulse adv 3 times within one frame -> ptr advances by exactly 1.
REQ-035 Write buf[ptr+3] = 8 while digit 0 is lit -> seg holds its old value until digit 0's next BLANK load, then shows 0000000.
REQ-036 Assert reset for 1 cycle during an ON phase of digit 1 -> next cycle an = 1111, seg = 1111111, ptr = 0; the scan restarts at digit 3.
